// File: rtl/iddmm_pkg.sv
// iddmm_pkg: shared state encoding and default sizing for the IDDMM result selector
package iddmm_pkg;
    localparam int IDDMM_K = 128;
    localparam int IDDMM_N = 16;
    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_DONE, SEND} state_t;
endpackage

// File: rtl/iddmm_word_buf.sv
// iddmm_word_buf: N x K word buffer, one synchronous write port, one asynchronous read port
// ports: clk, we/waddr/wdata write port, raddr/rdata combinational read port
module iddmm_word_buf #(
    parameter int K = 128,
    parameter int N = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [K-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [K-1:0]      rdata
);
    logic [K-1:0] mem [N];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/iddmm_result_sel.sv
// iddmm_result_sel: buffers a and (a - p) result streams, then streams out the one chosen by cal_sign
// ports: fifo_wr_* word strobes in, cal_done/cal_sign select pulse,
//        m_valid/m_ready/m_data/m_idx/m_last result stream out, busy and sticky err status
module iddmm_result_sel
    import iddmm_pkg::*;
#(
    parameter int K = IDDMM_K,
    parameter int N = IDDMM_N,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [K-1:0]      m_data,
    output logic [ADDR_W-1:0] m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              err
);
    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(N);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N-1);
    state_t state, state_n;
    logic [ADDR_W:0] cnt_a, cnt_s, cnt_a_n, cnt_s_n;
    logic [ADDR_W-1:0] rd;
    logic sel, done_seen, acc_a, acc_s, done_ok, fire, bad;
    logic [K-1:0] rdata_a, rdata_s;
    // strobes are accepted only while collecting and while their buffer has room
    assign acc_a   = fifo_wr_en_a && state != SEND && cnt_a != FULL;
    assign acc_s   = fifo_wr_en_sub && state != SEND && cnt_s != FULL;
    assign done_ok = cal_done && (state == COLLECT || state == WAIT_DONE);
    assign fire    = m_valid && m_ready;
    assign bad     = (fifo_wr_en_a && !acc_a) || (fifo_wr_en_sub && !acc_s) || (cal_done && !done_ok);
    assign cnt_a_n = cnt_a + (ADDR_W+1)'(acc_a);
    assign cnt_s_n = cnt_s + (ADDR_W+1)'(acc_s);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    // next-count lookahead lets the final strobe and cal_done in one cycle go straight to SEND
    always_comb begin
        state_n = state;
        case (state)
            IDLE:               if (acc_a || acc_s) state_n = COLLECT;
            COLLECT, WAIT_DONE: if (cnt_a_n == FULL && cnt_s_n == FULL)
                                    state_n = (done_seen || done_ok) ? SEND : WAIT_DONE;
            SEND:               if (m_ready && rd == LAST) state_n = IDLE;
            default:            state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_a     <= '0;
            cnt_s     <= '0;
            rd        <= '0;
            sel       <= 1'b0;
            done_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= err | bad;
            if (fire && rd == LAST) begin
                cnt_a     <= '0;
                cnt_s     <= '0;
                rd        <= '0;
                sel       <= 1'b0;
                done_seen <= 1'b0;
            end else begin
                cnt_a <= cnt_a_n;
                cnt_s <= cnt_s_n;
                if (done_ok) begin
                    sel       <= cal_sign;
                    done_seen <= 1'b1;
                end
                if (fire) rd <= rd + ADDR_W'(1);
            end
        end
    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_a (
        .clk(clk), .we(acc_a), .waddr(cnt_a[ADDR_W-1:0]), .wdata(fifo_wr_data_a),
        .raddr(rd), .rdata(rdata_a)
    );
    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_s (
        .clk(clk), .we(acc_s), .waddr(cnt_s[ADDR_W-1:0]), .wdata(fifo_wr_data_sub),
        .raddr(rd), .rdata(rdata_s)
    );
    assign m_valid = state == SEND;
    assign m_data  = m_valid ? (sel ? rdata_s : rdata_a) : '0;
    assign m_idx   = rd;
    assign m_last  = m_valid && rd == LAST;
    assign busy    = state != IDLE;
endmodule

// File: tb/tb_iddmm_result_sel.sv
// tb_iddmm_result_sel: randomized and directed transfers checked against a word-list reference model
module tb_iddmm_result_sel;
    localparam int K = 128;
    localparam int N = 16;
    localparam int AW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fifo_wr_en_a = 1'b0, fifo_wr_en_sub = 1'b0, cal_done = 1'b0, cal_sign = 1'b0, m_ready = 1'b0;
    logic [K-1:0] fifo_wr_data_a = '0, fifo_wr_data_sub = '0;
    logic m_valid, m_last, busy, err;
    logic [K-1:0] m_data;
    logic [AW-1:0] m_idx;
    int checks = 0;
    int errors = 0;
    bit err_exp = 1'b0;
    always #5 clk = ~clk;
    iddmm_result_sel #(.K(K), .N(N)) dut (
        .clk(clk), .rst(rst),
        .fifo_wr_en_a(fifo_wr_en_a), .fifo_wr_data_a(fifo_wr_data_a),
        .fifo_wr_en_sub(fifo_wr_en_sub), .fifo_wr_data_sub(fifo_wr_data_sub),
        .cal_done(cal_done), .cal_sign(cal_sign),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_last(m_last), .busy(busy), .err(err)
    );
    task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask
    task automatic idle_inputs();
        fifo_wr_en_a = 1'b0;
        fifo_wr_en_sub = 1'b0;
        cal_done = 1'b0;
        m_ready = 1'b0;
    endtask
    // done_mode: 0 = cal_done after all words, 1 = same cycle as final words, 2 = 5 cycles before the last word
    // pat: 0 = alternate A/S, 1 = random, 2 = A and S every cycle; rdy: 0 = always, 1 = toggle 1,0, 2 = random
    task automatic run(input int done_mode, input int pat, input int rdy, input bit sign,
                       input bit directed, input bit inject, input int abort_at);
        logic [K-1:0] av [N];
        logic [K-1:0] sv [N];
        bit ea [200];
        bit es [200];
        bit ed [200];
        logic [K-1:0] da [200];
        logic [K-1:0] ds [200];
        logic [K-1:0] held_d;
        logic [K-1:0] exp_w;
        logic [AW-1:0] held_i;
        bit held_v = 1'b0;
        int ia = 0, is = 0, c = 0, last, dc, e, got = 0, first = -1, cyc;
        for (int i = 0; i < N; i++) begin
            av[i] = directed ? K'(i) : {$urandom, $urandom, $urandom, $urandom};
            sv[i] = directed ? K'(32'h100 + i) : {$urandom, $urandom, $urandom, $urandom};
        end
        for (int k = 0; k < 200; k++) begin
            ea[k] = 1'b0; es[k] = 1'b0; ed[k] = 1'b0; da[k] = '0; ds[k] = '0;
        end
        while (ia < N || is < N) begin
            int r;
            r = pat == 0 ? (c % 2 == 0 ? 1 : 2) : pat == 2 ? 3 : (c == 0 ? 3 : int'($urandom_range(0, 3)));
            if (ia < N && (r == 1 || r == 3)) begin ea[c] = 1'b1; da[c] = av[ia]; ia++; end
            if (is < N && (r == 2 || r == 3)) begin es[c] = 1'b1; ds[c] = sv[is]; is++; end
            c++;
        end
        last = c - 1;
        dc = done_mode == 1 ? last : done_mode == 2 ? last - 5 : last + 1 + int'($urandom_range(0, 3));
        if (inject) begin
            dc = last + 3;
            ea[last + 1] = 1'b1;
            da[last + 1] = K'(32'hDEAD);
            err_exp = 1'b1;
        end
        ed[dc] = 1'b1;
        e = dc > last ? dc : last;
        for (cyc = 0; got < N && cyc < 300; cyc++) begin
            @(negedge clk);
            fifo_wr_en_a = cyc < 200 ? ea[cyc] : 1'b0;
            fifo_wr_data_a = cyc < 200 ? da[cyc] : '0;
            fifo_wr_en_sub = cyc < 200 ? es[cyc] : 1'b0;
            fifo_wr_data_sub = cyc < 200 ? ds[cyc] : '0;
            cal_done = cyc < 200 ? ed[cyc] : 1'b0;
            cal_sign = sign;
            m_ready = rdy == 0 ? 1'b1 : rdy == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (m_valid) begin
                if (first < 0) begin
                    first = cyc;
                    chk("first_word_latency", K'(first), K'(e + 1));
                end
                if (held_v) begin
                    chk("stall_data", m_data, held_d);
                    chk("stall_idx", K'(m_idx), K'(held_i));
                end
                if (m_ready) begin
                    exp_w = sign ? sv[got] : av[got];
                    chk("word_data", m_data, exp_w);
                    chk("word_idx", K'(m_idx), K'(got));
                    chk("word_last", K'(m_last), K'(got == N - 1));
                    got++;
                    held_v = 1'b0;
                    if (got == abort_at) begin
                        @(posedge clk);
                        #1 rst = 1'b1;
                        err_exp = 1'b0;
                        #1;
                        chk("abort_valid", K'(m_valid), K'(0));
                        chk("abort_data", m_data, '0);
                        chk("abort_busy", K'(busy), K'(0));
                        chk("abort_err", K'(err), K'(0));
                        @(negedge clk);
                        idle_inputs();
                        rst = 1'b0;
                        return;
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = m_data;
                    held_i = m_idx;
                end
            end else begin
                chk("idle_data_zero", m_data, '0);
            end
        end
        chk("word_count", K'(got), K'(N));
        @(negedge clk);
        idle_inputs();
        chk("end_busy", K'(busy), K'(0));
        chk("end_valid", K'(m_valid), K'(0));
        chk("end_err", K'(err), K'(err_exp));
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", K'(m_valid), K'(0));
        chk("rst_data", m_data, '0);
        chk("rst_idx", K'(m_idx), K'(0));
        chk("rst_last", K'(m_last), K'(0));
        chk("rst_busy", K'(busy), K'(0));
        chk("rst_err", K'(err), K'(0));
        rst = 1'b0;
        @(negedge clk);
        run(0, 0, 0, 1'b1, 1'b1, 1'b0, -1);
        run(0, 0, 1, 1'b0, 1'b1, 1'b0, -1);
        run(2, 2, 0, 1'b1, 1'b1, 1'b0, -1);
        run(0, 1, 2, 1'b0, 1'b0, 1'b1, -1);
        run(0, 1, 0, 1'b1, 1'b0, 1'b0, 7);
        run(0, 0, 2, 1'b0, 1'b1, 1'b0, -1);
        run(1, 2, 0, 1'b1, 1'b0, 1'b0, -1);
        for (int t = 0; t < 4; t++)
            run(t % 2 == 0 ? 0 : 2, 1, 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
        @(negedge clk);
        cal_done = 1'b1;
        cal_sign = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        chk("idle_done_err", K'(err), K'(1));
        chk("idle_done_busy", K'(busy), K'(0));
        chk("idle_done_valid", K'(m_valid), K'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iddmm_result_sel.md
IDDMM_RESULT_SEL -- requirements
Module: iddmm_result_sel

Interface
REQ-001 Parameter K, default 128, width in bits of one result word.
REQ-002 Parameter N, default 16, number of words per Montgomery result.
REQ-003 Parameter ADDR_W, default $clog2(N), word index width.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fifo_wr_en_a  input  1  strobe for one unreduced result word (a), least significant word first.
REQ-007 fifo_wr_data_a  input  K  unreduced result word.
REQ-008 fifo_wr_en_sub  input  1  strobe for one word of (a - p), least significant word first.
REQ-009 fifo_wr_data_sub  input  K  subtracted result word.
REQ-010 cal_done  input  1  one-cycle pulse, end of calculation.
REQ-011 cal_sign  input  1  valid with cal_done: 1 selects the sub stream, 0 selects the a stream.
REQ-012 m_valid  output  1  result word valid.
REQ-013 m_ready  input  1  downstream accepts the word.
REQ-014 m_data  output  K  selected result word.
REQ-015 m_idx  output  ADDR_W  index of m_data, 0 = least significant word.
REQ-016 m_last  output  1  high with word N-1.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 err  output  1  sticky protocol-error flag.

Function
REQ-019 The block shall hold two N x K buffers, A and S, with write counters cnt_a and cnt_s (ADDR_W+1 bits each).
REQ-020 States: IDLE, COLLECT, WAIT_DONE, SEND.
REQ-021 IDLE->COLLECT on any input strobe; the word presented in that same cycle shall be stored at index 0.
REQ-022 COLLECT: each strobe shall store its word at the current counter of its buffer and increment that counter; A and S strobes in the same cycle shall both be stored.
REQ-023 A cal_done pulse in COLLECT or WAIT_DONE shall latch cal_sign into sel and set done_seen.
REQ-024 COLLECT->WAIT_DONE when cnt_a==N and cnt_s==N and done_seen==0; COLLECT or WAIT_DONE->SEND when both counts equal N and done_seen==1, including when cal_done arrives in the same cycle as the last strobe.
REQ-025 SEND: m_valid=1 and m_data=(sel ? S[rd] : A[rd]), with m_idx=rd and m_last=(rd==N-1); rd shall advance on m_valid&&m_ready with no bubble cycle.
REQ-026 m_data and m_idx shall stay stable while m_valid && !m_ready.
REQ-027 A handshake with m_last=1 shall return the block to IDLE and clear the counters, rd, done_seen and sel.
REQ-028 The first word shall appear at most 1 cycle after the SEND entry condition is met.
REQ-029 A strobe while a counter equals N, any strobe in SEND, or cal_done in IDLE or SEND shall set err; the offending word or pulse shall be dropped.
REQ-030 err shall clear only on reset.
REQ-031 m_data shall be 0 whenever m_valid=0.

Reset
REQ-032 While rst=1, the state shall be IDLE and all counters, rd, sel and done_seen shall be 0.
REQ-033 While rst=1, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0 and err=0.
REQ-034 Buffer contents shall not be reset.
REQ-035 Asserting rst mid-COLLECT or mid-SEND shall abort the transfer; no partial word shall appear after rst is released.

Structure
REQ-036 Package iddmm_pkg shall hold the state enum and the default K and N constants.
REQ-037 Sub-module iddmm_word_buf (N x K, one write port, one asynchronous read port) shall be instantiated twice, once for A and once for S.

Verification
REQ-038 Scenario: N=16; A word i = i, S word i = 0x100+i, interleaved; then cal_done with cal_sign=1 and m_ready=1 -> 16 words 0x100..0x10F on consecutive cycles, m_last on 0x10F, then busy=0.
REQ-039 Scenario: same stimulus with cal_sign=0 and m_ready toggling 1,0 -> words 0..15 in order, each held stable through its stall cycle.
REQ-040 Scenario: cal_done arrives 5 cycles before the last S strobe -> m_valid rises within 1 cycle of the last strobe.
REQ-041 Scenario: a 17th A strobe (value 0xDEAD) -> err=1 and 0xDEAD never appears on m_data.
REQ-042 Scenario: rst pulse after rd=7 in SEND -> m_valid=0 immediately; the next full transfer delivers words 0..15 correctly with err=0.
REQ-043 Scenario: the last A strobe, last S strobe and cal_done in the same cycle -> the block enters SEND directly without WAIT_DONE.
